dispatch_queue: RTL

- In-order instruction buffer between decode (fetch/decode stage, 4-wide) and the out-of-order back end.
- Accepts up to 4 decoded uops per cycle, publishes the `num_fetch` credit back to fetch, and dispatches up to DISP_W uops per cycle in program order.
- Dispatch is gated by ROB space and per-class reservation-station credits (FXU, LD/ST, branch); each dispatched uop is assigned a ROB index.

---
 rtl/dispatch_queue_if.sv | 46 ++++
 rtl/dispatch_queue.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dispatch_queue_if.sv
// Decode-to-backend dispatch bus.
// Ports (slave view, as seen by dispatch_queue):
//   in : flush, flush_rob_tail, enq_count, enq_uop_flat, enq_class_flat,
//        rob_free, fxu_credit, ls_credit, br_credit
//   out: num_fetch, disp_count, disp_uop_flat, disp_class_flat,
//        disp_rob_idx_flat, rob_tail, count
interface dispatch_queue_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned UOP_W  = 32,
  parameter int unsigned DISP_W = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                    flush;
  logic [3:0]              flush_rob_tail;
  logic [2:0]              enq_count;
  logic [4*UOP_W-1:0]      enq_uop_flat;
  logic [11:0]             enq_class_flat;
  logic [2:0]              num_fetch;
  logic [4:0]              rob_free;
  logic [1:0]              fxu_credit;
  logic [1:0]              ls_credit;
  logic [1:0]              br_credit;
  logic [2:0]              disp_count;
  logic [DISP_W*UOP_W-1:0] disp_uop_flat;
  logic [3*DISP_W-1:0]     disp_class_flat;
  logic [4*DISP_W-1:0]     disp_rob_idx_flat;
  logic [3:0]              rob_tail;
  logic [CNT_W-1:0]        count;

  // Decode / back-end side
  modport master (
    output flush, flush_rob_tail, enq_count, enq_uop_flat, enq_class_flat,
           rob_free, fxu_credit, ls_credit, br_credit,
    input  num_fetch, disp_count, disp_uop_flat, disp_class_flat,
           disp_rob_idx_flat, rob_tail, count
  );

  // Queue side
  modport slave (
    input  flush, flush_rob_tail, enq_count, enq_uop_flat, enq_class_flat,
           rob_free, fxu_credit, ls_credit, br_credit,
    output num_fetch, disp_count, disp_uop_flat, disp_class_flat,
           disp_rob_idx_flat, rob_tail, count
  );
endinterface

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between 4-wide decode and the OoO back end.
// Ports:
//   clk, rst         : clock, async active-high reset
//   bus (slave)      : enqueue from decode, fetch credit, ROB/RS credits,
//                      up to DISP_W in-order dispatch lanes with ROB indices
module dispatch_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned UOP_W  = 32,
  parameter int unsigned DISP_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  dispatch_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [UOP_W-1:0] r_uop [DEPTH];
  logic [2:0]       r_cls [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_rob_tail;
  logic [2:0]       r_num_fetch;

  logic [2:0]              w_disp_cnt;
  logic [2:0]              w_acc;
  logic                    w_go;
  logic                    w_ok;
  logic [PTR_W-1:0]        w_idx;
  logic [2:0]              w_c;
  logic [2:0]              w_fu;
  logic [2:0]              w_lu;
  logic [2:0]              w_bu;
  logic [DISP_W*UOP_W-1:0] w_disp_uop;
  logic [3*DISP_W-1:0]     w_disp_cls;
  logic [4*DISP_W-1:0]     w_disp_rob;
  logic [CNT_W-1:0]        w_count_nxt;
  logic [CNT_W-1:0]        w_free;
  logic [2:0]              w_nf_nxt;

  // Dispatch selection: walk lanes oldest-first, stop at the first blocked uop.
  // w_fu/w_lu/w_bu count credits already consumed by older lanes this cycle.
  always_comb begin
    w_disp_cnt = '0;
    w_go       = 1'b1;
    w_ok       = 1'b0;
    w_idx      = '0;
    w_c        = '0;
    w_fu       = '0;
    w_lu       = '0;
    w_bu       = '0;
    w_disp_uop = '0;
    w_disp_cls = '0;
    w_disp_rob = '0;
    for (int k = 0; k < DISP_W; k++) begin
      w_idx = r_head + PTR_W'(k);
      w_c   = r_cls[w_idx];
      w_ok  = w_go && !bus.flush
              && (CNT_W'(k) < r_count)
              && (5'(k) < bus.rob_free)
              && (!w_c[0] || (3'(bus.fxu_credit) > w_fu))
              && (!w_c[1] || (3'(bus.ls_credit)  > w_lu))
              && (!w_c[2] || (3'(bus.br_credit)  > w_bu));
      if (w_ok) begin
        w_disp_cnt = w_disp_cnt + 3'd1;
        w_fu       = w_fu + 3'(w_c[0]);
        w_lu       = w_lu + 3'(w_c[1]);
        w_bu       = w_bu + 3'(w_c[2]);
        w_disp_uop[UOP_W*(DISP_W-1-k) +: UOP_W] = r_uop[w_idx];
        w_disp_cls[3*(DISP_W-1-k) +: 3]         = w_c;
        w_disp_rob[4*(DISP_W-1-k) +: 4]         = r_rob_tail + 4'(k);
      end else begin
        w_go = 1'b0;
      end
    end
  end

  // Excess enqueue slots beyond the published credit are dropped.
  assign w_acc = bus.flush ? 3'd0
               : ((bus.enq_count > r_num_fetch) ? r_num_fetch : bus.enq_count);

  assign w_count_nxt = r_count - CNT_W'(w_disp_cnt) + CNT_W'(w_acc);
  assign w_free      = CNT_W'(DEPTH) - w_count_nxt;
  assign w_nf_nxt    = (w_free > CNT_W'(4)) ? 3'd4 : 3'(w_free);

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_rob_tail  <= '0;
      r_num_fetch <= 3'd4;
    end else if (bus.flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_rob_tail  <= bus.flush_rob_tail;
      r_num_fetch <= 3'd4;
    end else begin
      r_head      <= r_head + PTR_W'(w_disp_cnt);
      r_tail      <= r_tail + PTR_W'(w_acc);
      r_count     <= w_count_nxt;
      r_rob_tail  <= r_rob_tail + 4'(w_disp_cnt);
      r_num_fetch <= w_nf_nxt;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < w_acc) begin
        r_uop[r_tail + PTR_W'(i)] <= bus.enq_uop_flat[UOP_W*(3-i) +: UOP_W];
        r_cls[r_tail + PTR_W'(i)] <= bus.enq_class_flat[3*(3-i) +: 3];
      end
    end
  end

  assign bus.num_fetch         = r_num_fetch;
  assign bus.disp_count        = w_disp_cnt;
  assign bus.disp_uop_flat     = w_disp_uop;
  assign bus.disp_class_flat   = w_disp_cls;
  assign bus.disp_rob_idx_flat = w_disp_rob;
  assign bus.rob_tail          = r_rob_tail;
  assign bus.count             = r_count;

endmodule
